// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding and ratio constants.
package clk_div_pkg;

   localparam int RATIO_W = 8;

   localparam logic [1:0] ENC_IDLE      = 2'd0;
   localparam logic [1:0] ENC_WAIT_RISE = 2'd1;
   localparam logic [1:0] ENC_MEAS_HIGH = 2'd2;
   localparam logic [1:0] ENC_MEAS_LOW  = 2'd3;

   localparam logic [RATIO_W-1:0] RATIO_BYPASS_0 = 8'd0;
   localparam logic [RATIO_W-1:0] RATIO_BYPASS_1 = 8'd1;

   typedef enum logic [1:0] {
      ST_IDLE      = ENC_IDLE,
      ST_WAIT_RISE = ENC_WAIT_RISE,
      ST_MEAS_HIGH = ENC_MEAS_HIGH,
      ST_MEAS_LOW  = ENC_MEAS_LOW
   } monState_e;

   // Ratios 0 and 1 mean the divider is bypassed, so there is nothing to measure.
   function automatic logic isBypassRatio(input logic [RATIO_W-1:0] ratio);
      return (ratio == RATIO_BYPASS_0) || (ratio == RATIO_BYPASS_1);
   endfunction

endpackage

// File: rtl/clk_edge_detect.sv
// Samples the same-domain divided clock once and flags its rising and falling edges.
module clk_edge_detect
   import clk_div_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic s_q;
   logic sPrev_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s_q     <= 1'b0;
         sPrev_q <= 1'b0;
      end else begin
         s_q     <= i_sig;
         sPrev_q <= s_q;
      end
   end

   assign o_rise = s_q & ~sPrev_q;
   assign o_fall = ~s_q & sPrev_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low phase and period of a divided clock in ref cycles and reports
// lock, mismatch and stall against the programmed divide ratio.
module clk_div_monitor
   import clk_div_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int LOCK_COUNT = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic               i_ref_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic               i_div_clk,
   input  logic [RATIO_W-1:0] i_expected_ratio,
   output logic [CNT_W-1:0]   o_meas_high,
   output logic [CNT_W-1:0]   o_meas_low,
   output logic [CNT_W:0]     o_meas_period,
   output logic               o_meas_valid,
   output logic               o_err,
   output logic               o_locked,
   output logic               o_timeout
);

   localparam int                PER_W       = CNT_W + 1;
   localparam int                MATCH_W     = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0]  RUN_MAX     = '1;
   localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT);
   localparam logic [MATCH_W-1:0] LOCK_VAL   = MATCH_W'(LOCK_COUNT);

   logic rise;
   logic fall;

   logic [CNT_W-1:0]   run_q;
   logic [CNT_W-1:0]   run_d;
   logic [RATIO_W-1:0] ratioPrev_q;

   monState_e          state_q;
   logic [CNT_W-1:0]   highLen_q;
   logic [MATCH_W-1:0] matchCnt_q;
   logic [CNT_W-1:0]   measHigh_q;
   logic [CNT_W-1:0]   measLow_q;
   logic [PER_W-1:0]   measPeriod_q;
   logic               measValid_q;
   logic               err_q;
   logic               timeout_q;

   logic               ratioChange;
   logic               bypass;
   logic               timeoutHit;
   logic [PER_W-1:0]   periodNow;
   logic               periodMatch;

   clk_edge_detect uEdge (
      .i_clk   (i_ref_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (i_div_clk),
      .o_rise  (rise),
      .o_fall  (fall)
   );

   // Length of the current phase: restarts at 1 on every edge and sticks at full scale.
   always_comb begin
      run_d = run_q;
      if (rise || fall) begin
         run_d = CNT_W'(1);
      end else if (run_q != RUN_MAX) begin
         run_d = run_q + 1'b1;
      end
   end

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_q       <= '0;
         ratioPrev_q <= '0;
      end else begin
         run_q       <= run_d;
         ratioPrev_q <= i_expected_ratio;
      end
   end

   assign ratioChange = (i_expected_ratio != ratioPrev_q);
   assign bypass      = isBypassRatio(i_expected_ratio);
   assign timeoutHit  = (run_q >= TIMEOUT_VAL) && !(rise || fall);
   assign periodNow   = {1'b0, highLen_q} + {1'b0, run_q};
   assign periodMatch = (periodNow == PER_W'(i_expected_ratio));

   // An edge in the same cycle as the stall limit always takes precedence over the stall.
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         highLen_q    <= '0;
         matchCnt_q   <= '0;
         measHigh_q   <= '0;
         measLow_q    <= '0;
         measPeriod_q <= '0;
         measValid_q  <= 1'b0;
         err_q        <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         measValid_q <= 1'b0;
         err_q       <= 1'b0;
         if (!i_en || bypass) begin
            state_q    <= ST_IDLE;
            matchCnt_q <= '0;
            timeout_q  <= 1'b0;
         end else if (ratioChange) begin
            state_q    <= ST_WAIT_RISE;
            matchCnt_q <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_WAIT_RISE;
               end
               ST_WAIT_RISE: begin
                  if (rise) begin
                     state_q   <= ST_MEAS_HIGH;
                     timeout_q <= 1'b0;
                  end else if (timeoutHit) begin
                     timeout_q  <= 1'b1;
                     matchCnt_q <= '0;
                  end
               end
               ST_MEAS_HIGH: begin
                  if (fall) begin
                     highLen_q <= run_q;
                     state_q   <= ST_MEAS_LOW;
                  end else if (timeoutHit) begin
                     timeout_q  <= 1'b1;
                     matchCnt_q <= '0;
                     state_q    <= ST_WAIT_RISE;
                  end
               end
               ST_MEAS_LOW: begin
                  if (rise) begin
                     measHigh_q   <= highLen_q;
                     measLow_q    <= run_q;
                     measPeriod_q <= periodNow;
                     measValid_q  <= 1'b1;
                     timeout_q    <= 1'b0;
                     state_q      <= ST_MEAS_HIGH;
                     if (periodMatch) begin
                        if (matchCnt_q != LOCK_VAL) begin
                           matchCnt_q <= matchCnt_q + 1'b1;
                        end
                     end else begin
                        matchCnt_q <= '0;
                        err_q      <= 1'b1;
                     end
                  end else if (timeoutHit) begin
                     timeout_q  <= 1'b1;
                     matchCnt_q <= '0;
                     state_q    <= ST_WAIT_RISE;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_meas_high   = measHigh_q;
   assign o_meas_low    = measLow_q;
   assign o_meas_period = measPeriod_q;
   assign o_meas_valid  = measValid_q;
   assign o_err         = err_q;
   assign o_locked      = (matchCnt_q == LOCK_VAL);
   assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: an ideal divider model drives i_div_clk and every valid
// pulse is compared with the phase split and lock history implied by the ratio.
module tb_clk_div_monitor;

   localparam int CNT_W      = 8;
   localparam int LOCK_COUNT = 4;
   localparam int TIMEOUT    = 255;

   logic             clock = 1'b0;
   logic             rstN;
   logic             en;
   logic             divClk;
   logic [7:0]       expRatio;
   logic [CNT_W-1:0] measHigh;
   logic [CNT_W-1:0] measLow;
   logic [CNT_W:0]   measPeriod;
   logic             measValid;
   logic             err;
   logic             locked;
   logic             timeoutFlag;

   int checks = 0;
   int errors = 0;

   int genRatio     = 0;
   int genPhase     = 0;
   int sinceChange  = 0;
   int cyc          = 0;
   int validCount   = 0;
   int lastValidCyc = -1;
   int lockRun      = 0;

   always #5 clock = ~clock;

   clk_div_monitor #(
      .CNT_W      (CNT_W),
      .LOCK_COUNT (LOCK_COUNT),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .i_ref_clk        (clock),
      .i_rst_n          (rstN),
      .i_en             (en),
      .i_div_clk        (divClk),
      .i_expected_ratio (expRatio),
      .o_meas_high      (measHigh),
      .o_meas_low       (measLow),
      .o_meas_period    (measPeriod),
      .o_meas_valid     (measValid),
      .o_err            (err),
      .o_locked         (locked),
      .o_timeout        (timeoutFlag)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Tracks how long the divided clock has been steady, in ref cycles.
   task automatic driveDiv(input logic v);
      if (v !== divClk) sinceChange = 0;
      divClk = v;
   endtask

   // One ref cycle: advance the ideal divider after the edge, then score the outputs.
   task automatic applyStimulus();
      @(posedge clock);
      cyc++;
      sinceChange++;
      #1;
      if (genRatio >= 2) begin
         genPhase = (genPhase + 1) % genRatio;
         driveDiv(genPhase < genRatio / 2);
      end else begin
         driveDiv(1'b0);
      end
      @(negedge clock);
      if (measValid === 1'b1) begin
         validCount++;
         if (genRatio < 2 || !en || expRatio < 8'd2) begin
            checkOutput("spuriousValid", 32'(measValid), 32'd0);
         end else begin
            checkOutput("measHigh", 32'(measHigh), 32'(genRatio / 2));
            checkOutput("measLow", 32'(measLow), 32'(genRatio - genRatio / 2));
            checkOutput("measPeriod", 32'(measPeriod), 32'(genRatio));
            checkOutput("errAtValid", 32'(err), 32'(genRatio != int'(expRatio)));
            if (lastValidCyc >= 0) checkOutput("validSpacing", 32'(cyc - lastValidCyc), 32'(genRatio));
            if (genRatio == int'(expRatio)) begin
               if (lockRun < LOCK_COUNT) lockRun++;
            end else begin
               lockRun = 0;
            end
            checkOutput("lockedAtValid", 32'(locked), 32'(lockRun == LOCK_COUNT));
            checkOutput("timeoutAtValid", 32'(timeoutFlag), 32'd0);
         end
         lastValidCyc = cyc;
      end else begin
         checkOutput("errWithoutValid", 32'(err), 32'd0);
      end
   endtask

   // Reprograms divider and expected ratio together; the divider restarts at a rising edge.
   task automatic reprogram(input int newExp, input int newGen);
      if (8'(newExp) != expRatio) lockRun = 0;
      expRatio     = 8'(newExp);
      genRatio     = newGen;
      genPhase     = 0;
      lastValidCyc = -1;
      driveDiv(newGen >= 2);
   endtask

   task automatic waitValids(input int n, input int budget, input string tag);
      int startCount;
      int spent;
      startCount = validCount;
      spent      = 0;
      while (validCount < startCount + n && spent < budget) begin
         applyStimulus();
         spent++;
      end
      checkOutput(tag, 32'(validCount - startCount), 32'(n));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "High"}, 32'(measHigh), 32'd0);
      checkOutput({tag, "Low"}, 32'(measLow), 32'd0);
      checkOutput({tag, "Period"}, 32'(measPeriod), 32'd0);
      checkOutput({tag, "Valid"}, 32'(measValid), 32'd0);
      checkOutput({tag, "Err"}, 32'(err), 32'd0);
      checkOutput({tag, "Locked"}, 32'(locked), 32'd0);
      checkOutput({tag, "Timeout"}, 32'(timeoutFlag), 32'd0);
   endtask

   initial begin
      int n;
      int e;
      int curExp;
      int spent;

      rstN     = 1'b0;
      en       = 1'b1;
      expRatio = 8'd0;
      divClk   = 1'b0;
      repeat (3) applyStimulus();
      checkAllZero("reset");
      rstN = 1'b1;
      applyStimulus();

      $display("[TB] ratio 4 lock");
      reprogram(4, 4);
      waitValids(6, 60, "t1Valids");
      checkOutput("t1Locked", 32'(locked), 32'd1);

      $display("[TB] ratio 7 lock");
      reprogram(7, 7);
      waitValids(5, 80, "t2Valids");
      checkOutput("t2Locked", 32'(locked), 32'd1);

      $display("[TB] expected 6 against divider 7");
      reprogram(6, 7);
      waitValids(5, 80, "t3Valids");
      checkOutput("t3Locked", 32'(locked), 32'd0);
      checkOutput("t3Period", 32'(measPeriod), 32'd7);

      $display("[TB] randomized ratios");
      curExp = 6;
      for (int r = 0; r < 6; r++) begin
         do n = int'($urandom_range(30, 2)); while (n == curExp);
         e = n;
         if ($urandom_range(2, 0) == 0) begin
            e = n + 1 + int'($urandom_range(3, 0));
            if (e == curExp) e = e + 1;
         end
         reprogram(e, n);
         curExp = e;
         waitValids(5, 8 * n + 20, "randValids");
      end

      $display("[TB] ratio change mid-period");
      reprogram(4, 4);
      waitValids(5, 60, "t5PreValids");
      checkOutput("t5PreLocked", 32'(locked), 32'd1);
      applyStimulus();
      reprogram(6, 6);
      applyStimulus();
      checkOutput("t5LockDrop", 32'(locked), 32'd0);
      waitValids(1, 30, "t5FirstValid");
      waitValids(3, 40, "t5MoreValids");
      checkOutput("t5Relock", 32'(locked), 32'd1);

      $display("[TB] stall after lock");
      reprogram(4, 4);
      waitValids(5, 60, "t4PreValids");
      reprogram(4, 0);
      spent = 0;
      while (sinceChange < TIMEOUT + 1 && spent < 400) begin
         applyStimulus();
         spent++;
      end
      checkOutput("t4BeforeLimit", 32'(timeoutFlag), 32'd0);
      checkOutput("t4LockedBeforeLimit", 32'(locked), 32'd1);
      applyStimulus();
      checkOutput("t4AtLimit", 32'(timeoutFlag), 32'd1);
      checkOutput("t4LockedAtLimit", 32'(locked), 32'd0);
      lockRun = 0;
      repeat (20) applyStimulus();
      checkOutput("t4TimeoutHeld", 32'(timeoutFlag), 32'd1);
      reprogram(4, 4);
      applyStimulus();
      checkOutput("t4TimeoutBeforeClear", 32'(timeoutFlag), 32'd1);
      applyStimulus();
      checkOutput("t4TimeoutCleared", 32'(timeoutFlag), 32'd0);
      waitValids(4, 40, "t4Relock");
      checkOutput("t4Relocked", 32'(locked), 32'd1);

      $display("[TB] enable dropped");
      en = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("enOffLocked", 32'(locked), 32'd0);
      checkOutput("enOffTimeout", 32'(timeoutFlag), 32'd0);
      repeat (10) applyStimulus();
      checkOutput("enOffPeriodHeld", 32'(measPeriod), 32'd4);
      checkOutput("enOffHighHeld", 32'(measHigh), 32'd2);
      en           = 1'b1;
      lockRun      = 0;
      lastValidCyc = -1;
      waitValids(5, 60, "enOnRelock");
      checkOutput("enOnLocked", 32'(locked), 32'd1);

      $display("[TB] reset in low phase, then bypass");
      reprogram(8, 8);
      waitValids(5, 80, "t6PreValids");
      spent = 0;
      while (genPhase != 6 && spent < 20) begin
         applyStimulus();
         spent++;
      end
      #2 rstN = 1'b0;
      #1 checkAllZero("asyncReset");
      lockRun = 0;
      reprogram(1, 8);
      applyStimulus();
      checkAllZero("inReset");
      rstN = 1'b1;
      for (int i = 0; i < 100; i++) begin
         applyStimulus();
         checkOutput("bypassValid", 32'(measValid), 32'd0);
         checkOutput("bypassErr", 32'(err), 32'd0);
         checkOutput("bypassTimeout", 32'(timeoutFlag), 32'd0);
         checkOutput("bypassLocked", 32'(locked), 32'd0);
         checkOutput("bypassPeriod", 32'(measPeriod), 32'd0);
      end
      reprogram(1, 0);
      for (int i = 0; i < 300; i++) begin
         applyStimulus();
         checkOutput("bypassStallTimeout", 32'(timeoutFlag), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
